// File: rtl/reconf_fir_mac_engine_if.sv
// Sample, coefficient-RAM and result signals of the FIR MAC engine.
// The slave modport is the engine side, master is the driver side.
interface reconf_fir_mac_engine_if #(
  parameter int NUM_TAPS = 33,
  parameter int DATA_W   = 3,
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 16,
  parameter int AW       = $clog2(NUM_TAPS)
);
  logic                     iEnSample;
  logic signed [DATA_W-1:0] iFirIn;
  logic [5:0]               iNumOfCoeff;
  logic                     iCoeffUpdate;
  logic                     iCsnRam;
  logic                     iWrnRam;
  logic [AW-1:0]            iAddrRam;
  logic signed [COEF_W-1:0] iWrDtRam;
  logic signed [OUT_W-1:0]  oFirOut;
  logic                     oFirValid;
  logic                     oBusy;
  logic                     oOverrun;

  modport master (
    output iEnSample, iFirIn, iNumOfCoeff, iCoeffUpdate, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
    input  oFirOut, oFirValid, oBusy, oOverrun
  );

  modport slave (
    input  iEnSample, iFirIn, iNumOfCoeff, iCoeffUpdate, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
    output oFirOut, oFirValid, oBusy, oOverrun
  );
endinterface

// File: rtl/reconf_fir_mac_engine.sv
// Time-multiplexed FIR core: LANES MAC lanes, run-time coefficients and tap count.
// Define FIR_OUT_SAT_EN to saturate the output; otherwise it wraps to OUT_W bits.
//
// state | meaning
// IDLE  | waiting for sample strobe, coefficient writes accepted
// MAC   | one group of LANES taps accumulated per cycle
// OUT   | scaled accumulator registered, valid pulse follows
module reconf_fir_mac_engine #(
  parameter int NUM_TAPS  = 33,
  parameter int LANES     = 4,
  parameter int DATA_W    = 3,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0,
  parameter int AW        = $clog2(NUM_TAPS)
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  reconf_fir_mac_engine_if.slave   bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW + 1;
  localparam int KW_MIN = $clog2(NUM_TAPS + LANES) + 1;
  localparam int KW     = (KW_MIN > 7) ? KW_MIN : 7;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q    [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic [KW-1:0]            neff_q, neff_d;
  logic [KW-1:0]            base_q, base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;
  logic                     shift_en;
  logic                     coef_we;
  logic [KW-1:0]            num_coef_clip;
  logic [KW-1:0]            base_nxt;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [OUT_W-1:0]  out_sel;

  assign num_coef_clip = (KW'(bus.iNumOfCoeff) > KW'(NUM_TAPS)) ? KW'(NUM_TAPS)
                                                                : KW'(bus.iNumOfCoeff);
  assign base_nxt = base_q + KW'(LANES);
  assign coef_we  = bus.iCoeffUpdate && !bus.iCsnRam && !bus.iWrnRam && (state_q == S_IDLE) &&
                    ({1'b0, bus.iAddrRam} < (AW+1)'(NUM_TAPS));

  // Lanes past Neff contribute nothing, so the last group may be partial.
  always_comb begin
    logic [KW-1:0]            k;
    logic signed [PROD_W-1:0] prod;
    lane_sum = '0;
    k        = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      k = base_q + KW'(l);
      if (k < neff_q) begin
        prod     = PROD_W'(x_q[k[AW-1:0]]) * PROD_W'(coef_q[k[AW-1:0]]);
        lane_sum = lane_sum + ACC_W'(prod);
      end
    end
  end

  assign scaled = acc_q >>> OUT_SHIFT;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

  always_comb begin
    if (scaled > OUT_MAX)      out_sel = OUT_W'(OUT_MAX);
    else if (scaled < OUT_MIN) out_sel = OUT_W'(OUT_MIN);
    else                       out_sel = OUT_W'(scaled);
  end
`else
  assign out_sel = OUT_W'(scaled);
`endif

  always_comb begin
    state_d  = state_q;
    neff_d   = neff_q;
    base_d   = base_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    ovr_d    = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iEnSample) begin
          shift_en = 1'b1;
          neff_d   = num_coef_clip;
          base_d   = '0;
          acc_d    = '0;
          state_d  = (num_coef_clip == '0) ? S_OUT : S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_q + lane_sum;
        base_d = base_nxt;
        if (base_nxt >= neff_q) state_d = S_OUT;
      end
      S_OUT: begin
        out_d   = out_sel;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.iEnSample && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q <= S_IDLE;
      neff_q  <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      neff_q  <= neff_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (shift_en) begin
        x_q[0] <= bus.iFirIn;
        for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (coef_we) coef_q[bus.iAddrRam] <= bus.iWrDtRam;
    end
  end

  assign bus.oFirOut   = out_q;
  assign bus.oFirValid = valid_q;
  assign bus.oBusy     = (state_q != S_IDLE);
  assign bus.oOverrun  = ovr_q;

endmodule

// File: tb/tb_reconf_fir_mac_engine.sv
// Directed bench for reconf_fir_mac_engine: vector table of samples with
// hand-computed outputs and latencies, plus overrun, write-guard and reset sequences.
module tb_reconf_fir_mac_engine;

  logic clk_sys = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_sys = ~clk_sys;

  reconf_fir_mac_engine_if #(.NUM_TAPS(33), .DATA_W(3), .COEF_W(16), .OUT_W(16)) bus ();

  reconf_fir_mac_engine #(
    .NUM_TAPS(33), .LANES(4), .DATA_W(3), .COEF_W(16), .OUT_W(16), .OUT_SHIFT(0)
  ) dut (
    .iClk_12M (clk_sys),
    .iRst     (rst),
    .bus      (bus)
  );

  typedef struct {
    logic signed [2:0] x;
    logic [5:0]        n;
    logic [15:0]       exp_out;
    int                exp_lat;
    bit                chk_out;
  } vec_t;

  vec_t vecs[$];

`ifdef FIR_OUT_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h7F9D;
`endif

  function automatic void add(input logic signed [2:0] x, input logic [5:0] n,
                              input logic [15:0] e, input int lat, input bit chk);
    vec_t v;
    v.x = x; v.n = n; v.exp_out = e; v.exp_lat = lat; v.chk_out = chk;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    bus.iCoeffUpdate = 1'b1;
    bus.iCsnRam      = 1'b0;
    bus.iWrnRam      = 1'b0;
    bus.iAddrRam     = 6'(addr);
    bus.iWrDtRam     = data;
    step();
    bus.iCoeffUpdate = 1'b0;
    bus.iCsnRam      = 1'b1;
    bus.iWrnRam      = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc;
    v = vecs[idx];
    bus.iEnSample   = 1'b1;
    bus.iFirIn      = v.x;
    bus.iNumOfCoeff = v.n;
    step();
    bus.iEnSample = 1'b0;
    cyc = 1;
    while (!bus.oFirValid && cyc < 40) begin
      step();
      cyc++;
    end
    check($sformatf("vec%0d latency", idx), 16'(cyc), 16'(v.exp_lat));
    if (v.chk_out) check($sformatf("vec%0d out", idx), bus.oFirOut, v.exp_out);
    step();
    check($sformatf("vec%0d valid_drop", idx), 16'(bus.oFirValid), 16'h0);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_lo, a_hi, b_chk, c_lo, c_hi, d_chk, e_lo, e_hi;
    int seen;

    // A: impulse through coef 0x100*(k+1), then N=0, N=1 and N=5 boundaries
    a_lo = vecs.size();
    add(3'sd1, 6'd10, 16'h0100, 5, 1'b1);
    for (int k = 1; k < 10; k++) add(3'sd0, 6'd10, 16'(16'h0100 * (k + 1)), 5, 1'b1);
    add(3'sd0,  6'd10, 16'h0000, 5, 1'b1);
    add(3'sd3,  6'd0,  16'h0000, 2, 1'b1);
    add(3'sd0,  6'd10, 16'h0600, 5, 1'b1);
    add(-3'sd1, 6'd1,  16'hFF00, 3, 1'b1);
    add(3'sd0,  6'd5,  16'h0A00, 4, 1'b1);
    a_hi = vecs.size() - 1;
    // B: delay line and coef[0] must be untouched by overrun and write during MAC
    b_chk = vecs.size();
    add(3'sd1, 6'd10, 16'h0F00, 5, 1'b1);
    // C: all-ones coefficients, ramp then hold; N=42 clips to 33
    c_lo = vecs.size();
    for (int i = 1; i <= 33; i++) add(3'sd1, 6'd33, 16'(i), 11, 1'b1);
    add(3'sd1, 6'd33, 16'd33, 11, 1'b1);
    add(3'sd1, 6'd42, 16'd33, 11, 1'b1);
    add(3'sd0, 6'd33, 16'd32, 11, 1'b1);
    c_hi = vecs.size() - 1;
    // D: after mid-MAC reset the delay line is empty again
    d_chk = vecs.size();
    add(3'sd1, 6'd33, 16'd1, 11, 1'b1);
    // E: full-scale coefficients with constant 3
    e_lo = vecs.size();
    for (int i = 1; i <= 32; i++) add(3'sd3, 6'd33, 16'h0, 11, 1'b0);
    add(3'sd3, 6'd33, SAT_EXP, 11, 1'b1);
    add(3'sd3, 6'd33, SAT_EXP, 11, 1'b1);
    e_hi = vecs.size() - 1;

    bus.iEnSample    = 1'b0;
    bus.iFirIn       = '0;
    bus.iNumOfCoeff  = '0;
    bus.iCoeffUpdate = 1'b0;
    bus.iCsnRam      = 1'b1;
    bus.iWrnRam      = 1'b1;
    bus.iAddrRam     = '0;
    bus.iWrDtRam     = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst out",     bus.oFirOut,          16'h0);
    check("rst valid",   16'(bus.oFirValid),   16'h0);
    check("rst busy",    16'(bus.oBusy),       16'h0);
    check("rst overrun", 16'(bus.oOverrun),    16'h0);

    for (int k = 0; k < 10; k++) write_coef(k, 16'(16'h0100 * (k + 1)));
    run_range(a_lo, a_hi);

    bus.iEnSample   = 1'b1;
    bus.iFirIn      = 3'sd0;
    bus.iNumOfCoeff = 6'd10;
    step();
    bus.iEnSample = 1'b0;
    check("B busy", 16'(bus.oBusy), 16'h1);
    write_coef(0, 16'h7000);
    step();
    bus.iEnSample = 1'b1;
    bus.iFirIn    = -3'sd4;
    step();
    bus.iEnSample = 1'b0;
    check("B overrun pulse", 16'(bus.oOverrun), 16'h1);
    step();
    check("B overrun drop", 16'(bus.oOverrun),  16'h0);
    check("B valid",        16'(bus.oFirValid), 16'h1);
    check("B out",          bus.oFirOut,        16'h0C00);
    step();
    check("B valid drop",   16'(bus.oFirValid), 16'h0);
    run_vec(b_chk);

    do_reset();
    for (int k = 0; k < 33; k++) write_coef(k, 16'h0001);
    write_coef(33, 16'h4000);
    run_range(c_lo, c_hi);

    bus.iEnSample   = 1'b1;
    bus.iFirIn      = 3'sd3;
    bus.iNumOfCoeff = 6'd33;
    step();
    bus.iEnSample = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.oFirValid) seen++;
      step();
    end
    check("D no valid", 16'(seen),         16'h0);
    check("D out",      bus.oFirOut,       16'h0);
    check("D busy",     16'(bus.oBusy),    16'h0);
    check("D overrun",  16'(bus.oOverrun), 16'h0);
    for (int k = 0; k < 33; k++) write_coef(k, 16'h0001);
    run_vec(d_chk);

    do_reset();
    for (int k = 0; k < 33; k++) write_coef(k, 16'h7FFF);
    run_range(e_lo, e_hi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
